// File: rtl/irq_ctrl.sv
// irq_ctrl: external interrupt controller feeding the CP0 exception logic.
// Synchronises raw device lines, latches edge/level pending bits, applies
// mask and global enable, and presents one prioritised request (lowest
// index wins) that is held in service from CP0 acceptance until eret.
module irq_ctrl #(
    parameter int                 NUM_IRQ     = 6,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = 6'b000011
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               int_enable,
    input  logic [NUM_IRQ-1:0] im,
    input  logic               ack,
    input  logic               eret,
    input  logic               clr_valid,
    input  logic [2:0]         clr_idx,
    output logic               int_req,
    output logic [3:0]         int_cause,
    output logic [2:0]         int_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [2:0]         id_q;
    logic [2:0]         id_d;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_out;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] active;
    logic               any_active;
    logic [2:0]         sel;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Multi-stage synchroniser chain per line; stage 0 samples the raw pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // One-cycle history of the synchronised lines for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_out;
        end
    end

    assign rise = sync_out & ~prev_q & EDGE_MASK;

    // Clear requests: software strobe, or CP0 acceptance of the current line
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (clr_valid && (clr_idx == 3'(i))) begin
                clr_mask[i] = 1'b1;
            end
            if ((state_q == REQ) && ack && (id_q == 3'(i))) begin
                clr_mask[i] = 1'b1;
            end
        end
    end

    // Edge lines: a new rise beats a simultaneous clear; level lines follow the sync output
    always_comb begin
        pending_d = (EDGE_MASK & (rise | (pending_q & ~clr_mask)))
                  | (~EDGE_MASK & sync_out);
    end

    // Pending register, visible unmasked to software
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign active     = pending_q & im;
    assign any_active = |active;

    // Fixed-priority encoder: scanning downwards leaves the lowest set index
    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel = 3'(i);
            end
        end
    end

    // State and request-id registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // Next-state logic; the id tracks the winner in REQ and freezes on acceptance
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (int_enable && any_active) begin
                    state_d = REQ;
                    id_d    = sel;
                end
            end
            REQ: begin
                if (ack) begin
                    state_d = SERVICE;
                end else if (!int_enable || !any_active) begin
                    state_d = IDLE;
                end else begin
                    id_d = sel;
                end
            end
            SERVICE: begin
                if (eret) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign int_req    = (state_q == REQ);
    assign in_service = (state_q == SERVICE);
    assign int_cause  = 4'b0000;
    assign int_id     = id_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench for irq_ctrl. A stimulus process drives
// directed and random inputs and pushes the reference model's expected
// outputs; a monitor process pops and compares after each clock edge.
module tb_irq_ctrl;

    localparam int         N    = 6;
    localparam int         SYNC = 2;
    localparam logic [5:0] EDGE = 6'b000011;

    logic       clk;
    logic       reset;
    logic [5:0] irq_in;
    logic       int_enable;
    logic [5:0] im;
    logic       ack;
    logic       eret;
    logic       clr_valid;
    logic [2:0] clr_idx;
    logic       int_req;
    logic [3:0] int_cause;
    logic [2:0] int_id;
    logic [5:0] pending;
    logic       in_service;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       req;
        int         id;
        logic [5:0] pend;
        logic       svc;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: states 0=idle, 1=requesting, 2=in service
    logic [5:0] hist[$];
    logic [5:0] m_s;
    logic [5:0] m_prev;
    logic [5:0] m_pend;
    int         m_state;
    int         m_id;

    irq_ctrl #(
        .NUM_IRQ    (N),
        .SYNC_STAGES(SYNC),
        .EDGE_MASK  (EDGE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .int_enable(int_enable),
        .im        (im),
        .ack       (ack),
        .eret      (eret),
        .clr_valid (clr_valid),
        .clr_idx   (clr_idx),
        .int_req   (int_req),
        .int_cause (int_cause),
        .int_id    (int_id),
        .pending   (pending),
        .in_service(in_service)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < SYNC; k++) hist.push_back(6'b0);
        m_s     = '0;
        m_prev  = '0;
        m_pend  = '0;
        m_state = 0;
        m_id    = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        logic [5:0] act;
        logic [5:0] nxt;
        int         winner;
        logic       cleared;
        act    = m_pend & im;
        winner = -1;
        for (int i = 0; i < N; i++) begin
            if (act[i] && winner < 0) winner = i;
        end
        for (int i = 0; i < N; i++) begin
            if (EDGE[i]) begin
                cleared = (clr_valid && int'(clr_idx) == i) ||
                          (m_state == 1 && ack && m_id == i);
                if (m_s[i] && !m_prev[i]) nxt[i] = 1'b1;
                else if (cleared)         nxt[i] = 1'b0;
                else                      nxt[i] = m_pend[i];
            end else begin
                nxt[i] = m_s[i];
            end
        end
        case (m_state)
            0: if (int_enable && winner >= 0) begin
                   m_state = 1;
                   m_id    = winner;
               end
            1: if (ack) m_state = 2;
               else if (!int_enable || winner < 0) m_state = 0;
               else m_id = winner;
            default: if (eret) m_state = 0;
        endcase
        m_pend = nxt;
        m_prev = m_s;
        hist.push_back(irq_in);
        hist.delete(0);
        m_s = hist[0];
    endtask

    // Predict the post-edge outputs, queue them, then let the edge happen
    task automatic apply_stimulus();
        exp_t e;
        model_edge();
        e.req  = (m_state == 1);
        e.svc  = (m_state == 2);
        e.id   = m_id;
        e.pend = m_pend;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare every queued prediction just after the clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("sb_int_req",    32'(int_req),    32'(e.req));
                check_output("sb_in_service", 32'(in_service), 32'(e.svc));
                check_output("sb_int_id",     32'(int_id),     e.id);
                check_output("sb_pending",    32'(pending),    32'(e.pend));
                check_output("sb_int_cause",  32'(int_cause),  0);
            end
        end
    end

    // Watchdog so the run always ends with a summary
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        reset      = 1'b1;
        irq_in     = '0;
        int_enable = 1'b0;
        im         = '0;
        ack        = 1'b0;
        eret       = 1'b0;
        clr_valid  = 1'b0;
        clr_idx    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_output("rst_int_req",    32'(int_req),    0);
        check_output("rst_in_service", 32'(in_service), 0);
        check_output("rst_pending",    32'(pending),    0);
        check_output("rst_int_id",     32'(int_id),     0);
        check_output("rst_int_cause",  32'(int_cause),  0);
        reset = 1'b0;

        $display("[TB] level line latency");
        irq_in = 6'b000100; im = 6'h3F; int_enable = 1'b1;
        repeat (3) apply_stimulus();
        check_output("t1_req_early", 32'(int_req), 0);
        apply_stimulus();
        check_output("t1_req",   32'(int_req), 1);
        check_output("t1_id",    32'(int_id),  2);

        $display("[TB] priority, ack and eret");
        irq_in = 6'b001001;
        repeat (4) apply_stimulus();
        check_output("t2_id0", 32'(int_id), 0);
        irq_in = 6'b001000; ack = 1'b1;
        apply_stimulus();
        ack = 1'b0;
        check_output("t2_svc",   32'(in_service), 1);
        check_output("t2_pend0", 32'(pending[0]), 0);
        repeat (2) apply_stimulus();
        eret = 1'b1;
        apply_stimulus();
        eret = 1'b0;
        check_output("t2_eret_req", 32'(int_req), 0);
        apply_stimulus();
        check_output("t2_rereq", 32'(int_req), 1);
        check_output("t2_id3",   32'(int_id),  3);

        $display("[TB] level drop before ack");
        irq_in = 6'b010000;
        repeat (4) apply_stimulus();
        check_output("t3_id4", 32'(int_id), 4);
        irq_in = 6'b000000;
        repeat (5) apply_stimulus();
        check_output("t3_idle", 32'(int_req), 0);

        $display("[TB] clear versus rise");
        im = 6'b000000; irq_in = 6'b000010;
        repeat (2) apply_stimulus();
        clr_valid = 1'b1; clr_idx = 3'd1;
        apply_stimulus();
        clr_valid = 1'b0;
        check_output("t4_set_wins", 32'(pending[1]), 1);
        clr_valid = 1'b1; clr_idx = 3'd1;
        apply_stimulus();
        clr_valid = 1'b0;
        check_output("t4_cleared", 32'(pending[1]), 0);
        irq_in = 6'b000000;
        repeat (3) apply_stimulus();
        irq_in = 6'b000010;
        repeat (3) apply_stimulus();
        clr_valid = 1'b1; clr_idx = 3'd7;
        apply_stimulus();
        clr_valid = 1'b0;
        check_output("t4_idx7", 32'(pending[1]), 1);

        $display("[TB] mask and global enable");
        irq_in = 6'b000000;
        repeat (3) apply_stimulus();
        irq_in = 6'h3F;
        repeat (3) apply_stimulus();
        check_output("t5_pend_all", 32'(pending), 32'h3F);
        apply_stimulus();
        check_output("t5_masked", 32'(int_req), 0);
        im = 6'b100000;
        apply_stimulus();
        check_output("t5_req5", 32'(int_req), 1);
        check_output("t5_id5",  32'(int_id),  5);
        int_enable = 1'b0;
        apply_stimulus();
        check_output("t5_disable", 32'(int_req), 0);

        $display("[TB] async reset in service");
        int_enable = 1'b1; im = 6'h3F;
        apply_stimulus();
        ack = 1'b1;
        apply_stimulus();
        ack = 1'b0;
        check_output("t6_svc", 32'(in_service), 1);
        #2 reset = 1'b1;
        #1;
        check_output("t6_rst_req",  32'(int_req),    0);
        check_output("t6_rst_svc",  32'(in_service), 0);
        check_output("t6_rst_pend", 32'(pending),    0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) apply_stimulus();
        check_output("t6_req_early", 32'(int_req), 0);
        apply_stimulus();
        check_output("t6_rereq", 32'(int_req), 1);

        $display("[TB] random traffic");
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) == 0) irq_in = 6'($urandom);
            if ($urandom_range(0, 15) == 0) im = 6'($urandom) | 6'($urandom);
            int_enable = ($urandom_range(0, 7) != 0);
            ack        = ($urandom_range(0, 2) == 0);
            eret       = ($urandom_range(0, 3) == 0);
            clr_valid  = ($urandom_range(0, 3) == 0);
            clr_idx    = 3'($urandom);
            apply_stimulus();
        end

        irq_in = '0; ack = 1'b0; eret = 1'b0; clr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_output("sb_drain", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
